axis_frame_arbiter: RTL and testbench
=====================================

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width of every tdata port.
REQ-002 Parameter IMG_HEIGHT, default 1440, lines per frame (tlast beats per frame).
REQ-003 Parameter IMG_WIDTH, default 2560, pixels per line; used only by verification, not checked by RTL.
REQ-004 clk  input  1  single clock for the whole block.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s0_axis_tdata / tvalid / tready / tuser / tlast  in/in/out/in/in  DATA_WIDTH/1/1/1/1  source 0 video stream; tuser marks start-of-frame (SOF).
REQ-007 s1_axis_tdata / tvalid / tready / tuser / tlast  in/in/out/in/in  DATA_WIDTH/1/1/1/1  source 1 video stream, same rules.
REQ-008 m_axis_tdata / tvalid / tready / tuser / tlast  out/out/in/out/out  DATA_WIDTH/1/1/1/1  shared output to the image-processing core.
REQ-009 grant  output  2  one-hot current owner (01 = source 0, 10 = source 1, 00 = none).
REQ-010 frame_done  output  1  one-cycle pulse when the last beat of a frame is accepted on m_axis.
REQ-011 sof_err  output  1  one-cycle pulse when a SOF arrives mid-frame on the granted source.

Function
REQ-012 States IDLE, GRANT0 and GRANT1 SHALL be held in a registered FSM.
REQ-013 In IDLE, source n requests when sn_tvalid=1 and sn_tuser=1.
REQ-014 In IDLE, a beat with tvalid=1 and tuser=0 SHALL be discarded (sn_tready=1 for that source) to resynchronise to frame start.
REQ-015 In IDLE, a requesting source SHALL see sn_tready=0 and its SOF beat SHALL be held until granted.
REQ-016 IDLE->GRANTn SHALL occur on the clock edge after the request; the SOF beat is forwarded from the GRANTn cycle onward (one cycle arbitration latency).
REQ-017 With both sources requesting, the grant SHALL go to the source not served last (round-robin); after reset, source 0 wins the first tie.
REQ-018 In GRANTn, m_axis_tdata/tvalid/tuser/tlast SHALL equal the granted source's signals combinationally, sn_tready SHALL equal m_axis_tready, and the other source's tready SHALL be 0.
REQ-019 A line counter of width clog2(IMG_HEIGHT) SHALL increment on each accepted beat (m_axis_tvalid & m_axis_tready) with tlast=1.
REQ-020 An accepted tlast beat while the line counter equals IMG_HEIGHT-1 SHALL pulse frame_done, clear the counter, update the last-served pointer and return to IDLE on the same edge.
REQ-021 An accepted beat on the granted source with tuser=1 and (line counter != 0 or a pixel of the current line already accepted) SHALL pulse sof_err, be forwarded, and restart the line counter at 0 without a grant change.
REQ-022 m_axis_tvalid, tuser and tlast SHALL be 0 in IDLE; grant SHALL equal 00 in IDLE.
REQ-023 Backpressure (m_axis_tready=0) SHALL hold all counters and state; no beat is lost or duplicated.
REQ-024 The non-granted source SHALL never be dropped from in GRANT states; its beats wait.

Reset
REQ-025 Reset SHALL force IDLE, grant=00, line counter=0, in-line flag=0, last-served pointer=source 1 (so source 0 wins first tie), frame_done=0, sof_err=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; m_axis_tvalid SHALL be 0 on the cycle after reset is sampled.

Structure
REQ-027 State encoding and the grant one-hot constants SHALL live in a shared package (img_pkg) used by the image-processing blocks.
REQ-028 The round-robin selector SHALL be one sub-module, rr_arb2 (2 requests, last-served pointer input, one-hot grant output); the rest is flat.

Verification (IMG_HEIGHT=4, IMG_WIDTH=8 at the bench)
REQ-029 Source 0 sends one 4x8 frame, m_axis_tready=1 -> grant=01 one cycle after SOF, 32 beats forwarded in order, frame_done pulses once on beat 32, grant=00 the cycle after.
REQ-030 Both sources present SOF in the same cycle after reset -> source 0 is served first, then source 1; frames are never interleaved; two frame_done pulses.
REQ-031 Source 1 starts with 5 beats without tuser, then a SOF -> the 5 beats are discarded (tready=1, m_axis_tvalid=0), the frame is forwarded normally.
REQ-032 m_axis_tready toggles 1,0,0,1 repeatedly during a frame -> output data is identical to the input sequence and frame_done fires only on the 32nd accepted beat.
REQ-033 Granted source sends SOF at line 2 -> sof_err pulses once, frame_done fires only after 4 further tlast beats.
REQ-034 Reset asserted at beat 10 of a frame -> grant=00 and m_axis_tvalid=0 the next cycle; the next SOF from either source is granted cleanly.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image-processing blocks: arbiter state encoding
// and the one-hot grant constants seen on the grant output.
package img_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the source that was not served last
// wins; a lone requester always wins.
module rr_arb2
    import img_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_lastServed,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = GRANT_NONE;
        if (i_req == 2'b11) begin
            o_grant = (i_lastServed == SRC1) ? GRANT_S0 : GRANT_S1;
        end else if (i_req[0]) begin
            o_grant = GRANT_S0;
        end else if (i_req[1]) begin
            o_grant = GRANT_S1;
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular arbiter: hands the shared AXI-Stream output to one video source
// at a time and only releases it after a complete frame of IMG_HEIGHT lines.
module axis_frame_arbiter
    import img_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_HEIGHT = 1440,
    parameter int IMG_WIDTH  = 2560
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tuser,
    input  logic                  s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tuser,
    input  logic                  s1_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic [1:0]            grant,
    output logic                  frame_done,
    output logic                  sof_err
);

    // Pixel count per line is not enforced in hardware; IMG_WIDTH only guards degenerate sizing.
    localparam int LINE_W = (IMG_WIDTH > 0 && IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(IMG_HEIGHT - 1);

    arb_state_t        r_state, w_nextState;
    logic [LINE_W-1:0] r_lineCnt, w_nextLineCnt, w_baseLine;
    logic              r_inLine, w_nextInLine;
    logic              r_lastServed, w_nextLastServed;
    logic [1:0]        w_req, w_rrGrant;
    logic              w_accept, w_sofErr, w_frameEnd;

    assign w_req = {s1_axis_tvalid & s1_axis_tuser, s0_axis_tvalid & s0_axis_tuser};

    rr_arb2 u_rrArb (
        .i_req        (w_req),
        .i_lastServed (r_lastServed),
        .o_grant      (w_rrGrant)
    );

    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tuser   = 1'b0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        grant          = GRANT_NONE;
        case (r_state)
            // Non-SOF beats are flushed to resynchronise; SOF beats stall until granted.
            ST_IDLE: begin
                s0_axis_tready = s0_axis_tvalid & ~s0_axis_tuser;
                s1_axis_tready = s1_axis_tvalid & ~s1_axis_tuser;
            end
            ST_GRANT0: begin
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tuser   = s0_axis_tuser;
                m_axis_tlast   = s0_axis_tlast;
                s0_axis_tready = m_axis_tready;
                grant          = GRANT_S0;
            end
            ST_GRANT1: begin
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tuser   = s1_axis_tuser;
                m_axis_tlast   = s1_axis_tlast;
                s1_axis_tready = m_axis_tready;
                grant          = GRANT_S1;
            end
            default: ;
        endcase
    end

    assign w_accept   = m_axis_tvalid & m_axis_tready;
    assign w_sofErr   = w_accept & m_axis_tuser & ((r_lineCnt != '0) | r_inLine);
    assign w_baseLine = w_sofErr ? '0 : r_lineCnt;
    assign w_frameEnd = w_accept & m_axis_tlast & (w_baseLine == LAST_LINE);
    assign frame_done = w_frameEnd;
    assign sof_err    = w_sofErr;

    always_comb begin
        w_nextState      = r_state;
        w_nextLineCnt    = r_lineCnt;
        w_nextInLine     = r_inLine;
        w_nextLastServed = r_lastServed;
        if (r_state == ST_IDLE) begin
            if (w_rrGrant == GRANT_S0) begin
                w_nextState = ST_GRANT0;
            end else if (w_rrGrant == GRANT_S1) begin
                w_nextState = ST_GRANT1;
            end
        // A mid-frame SOF counts as line 0 of a fresh frame on the same grant.
        end else if (w_accept) begin
            if (w_frameEnd) begin
                w_nextLineCnt    = '0;
                w_nextInLine     = 1'b0;
                w_nextLastServed = (r_state == ST_GRANT1) ? SRC1 : SRC0;
                w_nextState      = ST_IDLE;
            end else if (m_axis_tlast) begin
                w_nextLineCnt = w_baseLine + 1'b1;
                w_nextInLine  = 1'b0;
            end else begin
                w_nextLineCnt = w_baseLine;
                w_nextInLine  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_lineCnt    <= '0;
            r_inLine     <= 1'b0;
            r_lastServed <= SRC1;
        end else begin
            r_state      <= w_nextState;
            r_lineCnt    <= w_nextLineCnt;
            r_inLine     <= w_nextInLine;
            r_lastServed <= w_nextLastServed;
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Randomised frame traffic on both sources checked against a frame-level
// round-robin model of the expected output stream.
module tb_axis_frame_arbiter;

    localparam int DW = 8;
    localparam int H  = 4;
    localparam int W  = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
        logic          done;
        logic          serr;
        logic          junk;
        logic [1:0]    grant;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tuser, s0_axis_tlast;
    logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tuser, s1_axis_tlast;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic [1:0]    grant;
    logic          frame_done, sof_err;

    beat_t srcQ0[$], srcQ1[$], modQ0[$], modQ1[$], expQ[$];
    int    lenQ0[$], lenQ1[$];
    int    total = 0;
    int    bad = 0;
    int    acceptedCnt = 0;
    int    doneCnt = 0;
    int    serrCnt = 0;
    int    modelLast = 1;
    int    readyMode = 0;
    bit    gapsOn = 1'b0;
    logic  fire0, fire1;

    always #5 clk = ~clk;

    axis_frame_arbiter #(.DATA_WIDTH(DW), .IMG_HEIGHT(H), .IMG_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .s0_axis_tuser(s0_axis_tuser), .s0_axis_tlast(s0_axis_tlast),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
        .s1_axis_tuser(s1_axis_tuser), .s1_axis_tlast(s1_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .grant(grant), .frame_done(frame_done), .sof_err(sof_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue one frame (optionally preceded by non-SOF junk, optionally with a
    // restart SOF after sofLine lines) on a source.
    task automatic applyStimulus(input int src, input int sofLine, input int nJunk);
        beat_t b;
        int lines = sofLine + H;
        int beats = 0;
        for (int j = 0; j < nJunk; j++) begin
            b.data = DW'($urandom); b.user = 1'b0; b.last = (j == nJunk - 1);
            b.done = 1'b0; b.serr = 1'b0; b.junk = 1'b1; b.grant = 2'b00;
            if (src == 0) srcQ0.push_back(b); else srcQ1.push_back(b);
        end
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < W; p++) begin
                b.data  = DW'($urandom);
                b.user  = (p == 0) && (l == 0 || (sofLine > 0 && l == sofLine));
                b.last  = (p == W - 1);
                b.serr  = (sofLine > 0 && l == sofLine && p == 0);
                b.done  = (l == lines - 1 && p == W - 1);
                b.junk  = 1'b0;
                b.grant = (src == 0) ? 2'b01 : 2'b10;
                beats++;
                if (src == 0) begin srcQ0.push_back(b); modQ0.push_back(b); end
                else begin srcQ1.push_back(b); modQ1.push_back(b); end
            end
        end
        if (src == 0) lenQ0.push_back(beats); else lenQ1.push_back(beats);
    endtask

    // Whole frames leave in round-robin order, preferring the source not served last.
    task automatic buildExpected();
        int pick, len;
        while (lenQ0.size() > 0 || lenQ1.size() > 0) begin
            if (lenQ0.size() > 0 && lenQ1.size() > 0) pick = (modelLast == 1) ? 0 : 1;
            else pick = (lenQ0.size() > 0) ? 0 : 1;
            len = (pick == 0) ? lenQ0.pop_front() : lenQ1.pop_front();
            for (int k = 0; k < len; k++) begin
                if (pick == 0) expQ.push_back(modQ0.pop_front());
                else expQ.push_back(modQ1.pop_front());
            end
            modelLast = pick;
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        srcQ0.delete(); srcQ1.delete(); modQ0.delete(); modQ1.delete();
        expQ.delete(); lenQ0.delete(); lenQ1.delete();
        modelLast = 1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (expQ.size() > 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("frames_complete", 32'(expQ.size()), 0);
        @(negedge clk);
        checkOutput("grant_idle_after", 32'(grant), 0);
        checkOutput("m_tvalid_idle_after", 32'(m_axis_tvalid), 0);
    endtask

    initial begin
        s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tuser = 1'b0; s0_axis_tlast = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fire0 && srcQ0.size() > 0) srcQ0.delete(0);
            if (srcQ0.size() == 0) s0_axis_tvalid = 1'b0;
            else begin
                if (!s0_axis_tvalid || fire0)
                    s0_axis_tvalid = srcQ0[0].user || !gapsOn || ($urandom_range(0, 3) != 0);
                s0_axis_tdata = srcQ0[0].data; s0_axis_tuser = srcQ0[0].user; s0_axis_tlast = srcQ0[0].last;
            end
        end
    end

    initial begin
        s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tuser = 1'b0; s1_axis_tlast = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fire1 && srcQ1.size() > 0) srcQ1.delete(0);
            if (srcQ1.size() == 0) s1_axis_tvalid = 1'b0;
            else begin
                if (!s1_axis_tvalid || fire1)
                    s1_axis_tvalid = srcQ1[0].user || !gapsOn || ($urandom_range(0, 3) != 0);
                s1_axis_tdata = srcQ1[0].data; s1_axis_tuser = srcQ1[0].user; s1_axis_tlast = srcQ1[0].last;
            end
        end
    end

    initial begin
        int phase = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (readyMode)
                1: begin m_axis_tready = (phase == 0 || phase == 3); phase = (phase + 1) % 4; end
                2: m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // Handshakes are sampled mid-cycle, where they equal what the next rising edge sees.
    initial begin
        beat_t e;
        fire0 = 1'b0; fire1 = 1'b0;
        forever begin
            @(negedge clk);
            fire0 = s0_axis_tvalid && s0_axis_tready && !reset;
            fire1 = s1_axis_tvalid && s1_axis_tready && !reset;
            if (!reset && s1_axis_tvalid && srcQ1.size() > 0 && srcQ1[0].junk) begin
                checkOutput("junk_s1_tready", 32'(s1_axis_tready), 1);
                checkOutput("junk_m_tvalid", 32'(m_axis_tvalid), 0);
            end
            if (!reset && m_axis_tvalid && m_axis_tready) begin
                acceptedCnt++;
                if (frame_done) doneCnt++;
                if (sof_err) serrCnt++;
                if (expQ.size() == 0) checkOutput("unexpected_beat", 32'(m_axis_tvalid), 0);
                else begin
                    e = expQ.pop_front();
                    checkOutput("tdata", 32'(m_axis_tdata), 32'(e.data));
                    checkOutput("tuser", 32'(m_axis_tuser), 32'(e.user));
                    checkOutput("tlast", 32'(m_axis_tlast), 32'(e.last));
                    checkOutput("grant", 32'(grant), 32'(e.grant));
                    checkOutput("frame_done", 32'(frame_done), 32'(e.done));
                    checkOutput("sof_err", 32'(sof_err), 32'(e.serr));
                end
            end else if (!reset) begin
                checkOutput("frame_done_no_beat", 32'(frame_done), 0);
                checkOutput("sof_err_no_beat", 32'(sof_err), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired pending=%0d", expQ.size());
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base, n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_grant", 32'(grant), 0);
        checkOutput("reset_m_tvalid", 32'(m_axis_tvalid), 0);
        checkOutput("reset_frame_done", 32'(frame_done), 0);
        checkOutput("reset_sof_err", 32'(sof_err), 0);

        $display("[TB] single frame from source 0");
        applyStimulus(0, 0, 0);
        buildExpected();
        @(negedge clk);
        checkOutput("sof_held_tready", 32'(s0_axis_tready), 0);
        checkOutput("sof_cycle_grant", 32'(grant), 0);
        @(negedge clk);
        checkOutput("grant_after_sof", 32'(grant), 32'h1);
        waitDone(200);
        checkOutput("done_count_single", 32'(doneCnt), 1);

        $display("[TB] simultaneous SOF after reset");
        doReset();
        doneCnt = 0;
        @(negedge clk);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        buildExpected();
        waitDone(400);
        checkOutput("done_count_tie", 32'(doneCnt), 2);

        $display("[TB] junk beats before SOF on source 1");
        applyStimulus(1, 0, 5);
        buildExpected();
        waitDone(300);

        $display("[TB] backpressure pattern 1,0,0,1");
        readyMode = 1;
        doneCnt = 0;
        applyStimulus(0, 0, 0);
        buildExpected();
        waitDone(600);
        checkOutput("done_count_backpressure", 32'(doneCnt), 1);
        readyMode = 0;

        $display("[TB] SOF restart at line 2");
        serrCnt = 0;
        doneCnt = 0;
        applyStimulus(1, 2, 0);
        buildExpected();
        waitDone(400);
        checkOutput("sof_err_count", 32'(serrCnt), 1);
        checkOutput("done_count_restart", 32'(doneCnt), 1);

        $display("[TB] reset at beat 10");
        base = acceptedCnt;
        n = 0;
        applyStimulus(0, 0, 0);
        buildExpected();
        while (acceptedCnt - base < 10 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("beats_before_reset", 32'(acceptedCnt - base), 10);
        doReset();
        @(negedge clk);
        checkOutput("abort_grant", 32'(grant), 0);
        checkOutput("abort_m_tvalid", 32'(m_axis_tvalid), 0);
        applyStimulus(1, 0, 0);
        buildExpected();
        waitDone(300);

        $display("[TB] randomised gaps and backpressure, two frames per source");
        readyMode = 2;
        gapsOn = 1'b1;
        doneCnt = 0;
        serrCnt = 0;
        applyStimulus(0, 0, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        buildExpected();
        waitDone(4000);
        checkOutput("done_count_random", 32'(doneCnt), 4);
        checkOutput("sof_err_count_random", 32'(serrCnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
